// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register stack and its execution engine.
package instr_register_pkg;

  localparam int NUM_ENTRIES = 32;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [4:0]         address_t;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rezultat;
  } instruction_t;

  // DIV is already taken by the opcode, so the engine states carry a prefix.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ALU  = 2'd1,
    ST_DIV  = 2'd2
  } exec_state_t;

  // One pending execution: which entry, and which write of that entry it belongs to.
  typedef struct packed {
    address_t addr;
    logic     gen;
  } qentry_t;

  function automatic logic is_divop(opcode_t o);
    return (o == DIV) || (o == MOD);
  endfunction

endpackage

// File: rtl/instr_seq_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per cycle,
// W cycles after start. done_o is a one-cycle pulse once the count expires.
module instr_seq_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [W:0]    shifted, trial;

  // Trial subtraction of the divisor from the partial remainder shifted by one bit.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  // Load on start, then iterate while the down-counter is non-zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= CW'(W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
        quo_q <= {quo_q[W-2:0], ~trial[W]};
        rem_q <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o      = busy_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/instr_exec_register.sv
// 32-entry instruction register stack with a background execution engine.
// Writes are queued as {entry, generation}; one shared engine drains the queue
// and commits each result only if the entry has not been rewritten meanwhile.
// Optional build macro: INSTR_EXEC_DIVZERO_FLAG_EN adds the div_by_zero pulse output.
//
//   state   | meaning
//   ST_IDLE | waiting for a queued entry; pops one when the queue is non-empty
//   ST_ALU  | single-cycle op (incl. DIV/MOD by zero) commits on the next edge
//   ST_DIV  | divider iterating; commits when the divider signals done
module instr_exec_register
  import instr_register_pkg::*;
#(
  parameter int QDEPTH   = 8,
  parameter int DIV_ITER = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_en,
  output logic         write_ready,
  input  operand_t     operand_a,
  input  operand_t     operand_b,
  input  opcode_t      opcode,
  input  address_t     write_pointer,
  input  address_t     read_pointer,
  output instruction_t instruction_word,
  output logic         result_valid,
  output logic         busy
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  ,
  output logic         div_by_zero
`endif
);

  localparam int QAW = $clog2(QDEPTH);

  instruction_t            entries_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0]  done_q, gen_q;

  qentry_t                 queue_q [QDEPTH];
  logic [QAW-1:0]          qwr_q, qrd_q;
  logic [QAW:0]            qcnt_q;

  exec_state_t             state_q;
  address_t                exec_addr_q;
  logic                    exec_gen_q;
  opcode_t                 exec_opc_q;
  operand_t                exec_a_q, exec_b_q;

  qentry_t                 head;
  opcode_t                 head_opc;
  operand_t                head_a, head_b;
  logic                    head_divides;
  logic                    push, pop, div_start, div_done;
  logic [DIV_ITER-1:0]     dvd_mag, dvs_mag, div_quo, div_rem;
  result_t                 a64, b64, alu_res, quo64, rem64, div_res, commit_res;
  logic                    commit, commit_ok;

  assign write_ready = (qcnt_q != (QAW+1)'(QDEPTH));
  assign busy        = (state_q != ST_IDLE) || (qcnt_q != '0);
  assign push        = load_en && write_ready;
  assign pop         = (state_q == ST_IDLE) && (qcnt_q != '0);

  assign head         = queue_q[qrd_q];
  assign head_opc     = entries_q[head.addr].opc;
  assign head_a       = entries_q[head.addr].op_a;
  assign head_b       = entries_q[head.addr].op_b;
  assign head_divides = is_divop(head_opc) && (head_b != '0);
  assign div_start    = pop && head_divides;

  assign dvd_mag = head_a[31] ? (~head_a + 32'd1) : head_a;
  assign dvs_mag = head_b[31] ? (~head_b + 32'd1) : head_b;

  instr_seq_divider #(.W(DIV_ITER)) u_div (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (div_start),
    .dividend_i  (dvd_mag),
    .divisor_i   (dvs_mag),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Single-cycle results; DIV/MOD reach here only with a zero divisor.
  always_comb begin
    a64     = {{32{exec_a_q[31]}}, exec_a_q};
    b64     = {{32{exec_b_q[31]}}, exec_b_q};
    alu_res = '0;
    unique case (exec_opc_q)
      PASSA:   alu_res = a64;
      PASSB:   alu_res = b64;
      ADD:     alu_res = a64 + b64;
      SUB:     alu_res = a64 - b64;
      MULT:    alu_res = a64 * b64;
      default: alu_res = '0;
    endcase
  end

  // Sign correction: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    quo64   = {{(64-DIV_ITER){1'b0}}, div_quo};
    rem64   = {{(64-DIV_ITER){1'b0}}, div_rem};
    div_res = (exec_opc_q == MOD) ? (exec_a_q[31] ? -rem64 : rem64)
                                  : ((exec_a_q[31] ^ exec_b_q[31]) ? -quo64 : quo64);
  end

  assign commit     = (state_q == ST_ALU) || ((state_q == ST_DIV) && div_done);
  assign commit_res = (state_q == ST_DIV) ? div_res : alu_res;
  assign commit_ok  = commit && (gen_q[exec_addr_q] == exec_gen_q);

  // Engine FSM: pop in idle and snapshot the entry, then wait for the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      exec_addr_q <= '0;
      exec_gen_q  <= 1'b0;
      exec_opc_q  <= ZERO;
      exec_a_q    <= '0;
      exec_b_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            exec_addr_q <= head.addr;
            exec_gen_q  <= head.gen;
            exec_opc_q  <= head_opc;
            exec_a_q    <= head_a;
            exec_b_q    <= head_b;
            state_q     <= head_divides ? ST_DIV : ST_ALU;
          end
        end
        ST_ALU:  state_q <= ST_IDLE;
        ST_DIV:  if (div_done) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qwr_q  <= '0;
      qrd_q  <= '0;
      qcnt_q <= '0;
    end else begin
      if (push) qwr_q <= qwr_q + QAW'(1);
      if (pop)  qrd_q <= qrd_q + QAW'(1);
      unique case ({push, pop})
        2'b10:   qcnt_q <= qcnt_q + (QAW+1)'(1);
        2'b01:   qcnt_q <= qcnt_q - (QAW+1)'(1);
        default: qcnt_q <= qcnt_q;
      endcase
    end
  end

  // Queue storage; the pushed generation is the one this write toggles to.
  always_ff @(posedge clk) begin
    if (push) queue_q[qwr_q] <= '{addr: write_pointer, gen: ~gen_q[write_pointer]};
  end

  // Register stack; a write in the same cycle as a commit to that entry wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= '0;
      done_q <= '1;
      gen_q  <= '0;
    end else begin
      if (commit_ok) begin
        entries_q[exec_addr_q].rezultat <= commit_res;
        done_q[exec_addr_q]             <= 1'b1;
      end
      if (push) begin
        entries_q[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b, rezultat: '0};
        done_q[write_pointer]    <= 1'b0;
        gen_q[write_pointer]     <= ~gen_q[write_pointer];
      end
    end
  end

`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  logic dz_q;

  // One-cycle flag after a committed DIV/MOD with a zero divisor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dz_q <= 1'b0;
    else          dz_q <= commit_ok && is_divop(exec_opc_q) && (exec_b_q == '0);
  end

  assign div_by_zero = dz_q;
`endif

  assign instruction_word = entries_q[read_pointer];
  assign result_valid     = done_q[read_pointer];

endmodule

// File: tb/tb_instr_exec_register.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level reference model of the register stack and engine.
module tb_instr_exec_register;
  import instr_register_pkg::*;

  localparam int QDEPTH   = 8;
  localparam int DIV_ITER = 32;
  localparam int IW       = $bits(instruction_t);

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load_en = 1'b0;
  logic         write_ready;
  operand_t     operand_a = '0;
  operand_t     operand_b = '0;
  opcode_t      opcode = ZERO;
  address_t     write_pointer = '0;
  address_t     read_pointer = '0;
  instruction_t instruction_word;
  logic         result_valid;
  logic         busy;
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
  logic         div_by_zero;
`endif

  always #5 clk = ~clk;

  instr_exec_register #(.QDEPTH(QDEPTH), .DIV_ITER(DIV_ITER)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_en          (load_en),
    .write_ready      (write_ready),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .opcode           (opcode),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .result_valid     (result_valid),
    .busy             (busy)
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
    ,
    .div_by_zero      (div_by_zero)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int addr;
    bit gen;
  } qent_t;

  opcode_t m_opc  [NUM_ENTRIES];
  int      m_a    [NUM_ENTRIES];
  int      m_b    [NUM_ENTRIES];
  longint  m_res  [NUM_ENTRIES];
  bit      m_done [NUM_ENTRIES];
  bit      m_gen  [NUM_ENTRIES];
  qent_t   mq[$];
  bit      e_act;
  int      e_left;
  int      e_addr;
  bit      e_gen;
  longint  e_res;
  bit      e_dz;
  bit      m_dz;

  function automatic longint ref_exec(opcode_t o, int a, int b);
    longint la = a;
    longint lb = b;
    case (o)
      PASSA:   return la;
      PASSB:   return lb;
      ADD:     return la + lb;
      SUB:     return la - lb;
      MULT:    return la * lb;
      DIV:     return (b == 0) ? 64'sd0 : la / lb;
      MOD:     return (b == 0) ? 64'sd0 : la % lb;
      default: return 64'sd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      m_opc[i] = ZERO; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0;
      m_done[i] = 1'b1; m_gen[i] = 1'b0;
    end
    mq.delete();
    e_act = 1'b0; e_left = 0; m_dz = 1'b0;
  endtask

  // Effect of one clock edge with the given inputs.
  task automatic model_step(input bit le, input opcode_t o, input int a, input int b, input int wp);
    bit    full = (mq.size() == QDEPTH);
    bit    was_idle = !e_act;
    qent_t qe;
    m_dz = 1'b0;
    if (e_act) begin
      e_left--;
      if (e_left == 0) begin
        e_act = 1'b0;
        if (m_gen[e_addr] == e_gen) begin
          m_res[e_addr]  = e_res;
          m_done[e_addr] = 1'b1;
          m_dz           = e_dz;
        end
      end
    end
    if (was_idle && mq.size() != 0) begin
      qe     = mq.pop_front();
      e_act  = 1'b1;
      e_addr = qe.addr;
      e_gen  = qe.gen;
      e_res  = ref_exec(m_opc[qe.addr], m_a[qe.addr], m_b[qe.addr]);
      e_dz   = (m_opc[qe.addr] == DIV || m_opc[qe.addr] == MOD) && m_b[qe.addr] == 0;
      e_left = e_dz ? 1 : ((m_opc[qe.addr] == DIV || m_opc[qe.addr] == MOD) ? DIV_ITER + 1 : 1);
    end
    if (le && !full) begin
      m_opc[wp] = o; m_a[wp] = a; m_b[wp] = b; m_res[wp] = 0;
      m_done[wp] = 1'b0;
      m_gen[wp]  = ~m_gen[wp];
      mq.push_back('{addr: wp, gen: m_gen[wp]});
    end
  endtask

  task automatic compare_all();
    instruction_t e;
    int rp = int'(read_pointer);
    e.opc = m_opc[rp]; e.op_a = m_a[rp]; e.op_b = m_b[rp]; e.rezultat = m_res[rp];
    chk("iw", instruction_word, e);
    chk("valid", result_valid, m_done[rp]);
    chk("wready", write_ready, mq.size() != QDEPTH);
    chk("busy", busy, e_act || mq.size() != 0);
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
    chk("dz", div_by_zero, m_dz);
`endif
  endtask

  // Drive inputs at a falling edge, advance one rising edge, check at the next falling edge.
  task automatic step(input bit le, input opcode_t o, input int a, input int b, input int wp, input int rp);
    load_en = le; opcode = o; operand_a = a; operand_b = b;
    write_pointer = address_t'(wp); read_pointer = address_t'(rp);
    model_step(le, o, a, b, wp);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int rp);
    step(1'b0, ZERO, 0, 0, 0, rp);
  endtask

  task automatic drain(input int rp);
    int n = 0;
    while (busy && n < 2000) begin idle(rp); n++; end
    chk("drain_timeout", busy, 1'b0);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 4))
      0:       return int'($urandom_range(0, 40)) - 20;
      1:       return int'($urandom);
      2:       return 32'h8000_0000;
      3:       return -1;
      default: return int'($urandom_range(0, 2000)) - 1000;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_wready", write_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;

    // Reset contents of every entry.
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      read_pointer = address_t'(i);
      @(negedge clk);
      chk("rst_iw", instruction_word, '0);
      chk("rst_valid", result_valid, 1'b1);
    end

    // ADD commits two edges after the write.
    step(1'b1, ADD, -7, 12, 3, 3);
    chk("add_pending", result_valid, 1'b0);
    idle(3);
    chk("add_pending2", result_valid, 1'b0);
    idle(3);
    chk("add_valid", result_valid, 1'b1);
    chk("add_res", instruction_word.rezultat, 64'sd5);

    // DIV latency and signed results.
    step(1'b1, DIV, -15, 4, 9, 9);
    lat = 0;
    while (!result_valid && lat < 200) begin idle(9); lat++; end
    chk("div_latency", lat, DIV_ITER + 2);
    chk("div_res", instruction_word.rezultat, -64'sd3);
    step(1'b1, MOD, -15, 4, 9, 9);
    lat = 0;
    while (!result_valid && lat < 200) begin idle(9); lat++; end
    chk("mod_latency", lat, DIV_ITER + 2);
    chk("mod_res", instruction_word.rezultat, -64'sd3);

    // Divide by zero completes like a single-cycle op.
    step(1'b1, ADD, 40, 2, 10, 10);
    idle(10); idle(10);
    chk("pre_dz_res", instruction_word.rezultat, 64'sd42);
    step(1'b1, DIV, 13, 0, 10, 10);
    idle(10); idle(10);
    chk("dz_valid", result_valid, 1'b1);
    chk("dz_res", instruction_word.rezultat, 64'sd0);
`ifdef INSTR_EXEC_DIVZERO_FLAG_EN
    chk("dz_pulse", div_by_zero, 1'b1);
    idle(10);
    chk("dz_clear", div_by_zero, 1'b0);
`endif

    // Queue fill: nine DIVs, the tenth write is dropped.
    for (int k = 0; k < 9; k++) step(1'b1, DIV, 1000 + k, 3, 11 + k, 20);
    chk("fill_wready", write_ready, 1'b0);
    step(1'b1, ADD, 5, 5, 20, 20);
    chk("fill_drop_iw", instruction_word, '0);
    chk("fill_drop_valid", result_valid, 1'b1);
    drain(11);
    read_pointer = address_t'(19);
    #1;
    chk("fill_last_res", instruction_word.rezultat, 64'sd336);
    @(negedge clk);

    // Rewrite during a divide: stale quotient must never land.
    step(1'b1, DIV, 100, 7, 4, 4);
    repeat (5) idle(4);
    step(1'b1, PASSB, 0, 6, 4, 4);
    seen = 1'b0;
    for (int n = 0; n < 200 && busy; n++) begin
      idle(4);
      if (instruction_word.rezultat == 64'sd14) seen = 1'b1;
    end
    chk("rewrite_no_stale", seen, 1'b0);
    chk("rewrite_res", instruction_word.rezultat, 64'sd6);
    chk("rewrite_valid", result_valid, 1'b1);

    // Asynchronous reset in the middle of a divide.
    step(1'b1, DIV, -99, 5, 7, 7);
    repeat (5) idle(7);
    step(1'b1, ADD, 1, 2, 8, 7);
    #2;
    reset_n = 1'b0;
    load_en = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_wready", write_ready, 1'b1);
    chk("mid_rst_iw", instruction_word, '0);
    chk("mid_rst_valid", result_valid, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    compare_all();

    // Random traffic with heavy reuse of a few entries.
    for (int n = 0; n < 800; n++) begin
      opcode_t o = opcode_t'($urandom_range(0, 7));
      int      b = ($urandom_range(0, 5) == 0) ? 0 : pick();
      step(bit'($urandom_range(0, 1)), o, pick(), b,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 8)));
    end
    drain(0);
    for (int i = 0; i < 8; i++) begin
      read_pointer = address_t'(i);
      @(negedge clk);
      compare_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
